symbol_mapper: RTL and testbench
================================

# symbol_mapper

Transmit-side BPSK/QPSK symbol mapper: the inverse of the receive slicer. It accepts packed bytes on an internal valid/ready/last stream and unpacks them LSB-first into K bits per symbol (K=1 for BPSK, K=2 for QPSK). It emits one Q1.15 constellation point per beat as {I[15:0], Q[15:0]}. It sits in the `clk_bb` baseband domain between the framer/scrambler byte stream and the pulse-shaping filter, with static control from the CSR block.

## Interface
- `AMP_BPSK`, default 16'h7FFF, BPSK magnitude (Q1.15), applied on I only.
- `AMP_QPSK`, default 16'h5A82, QPSK per-rail magnitude (Q1.15, ≈0.7071).
- `SYM_COUNT_W`, default 32, width of the symbol counter.

Ports:
- `clk_bb`  in  1  baseband clock; only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ctrl_enable`  in  1  gates byte acceptance only.
- `ctrl_bypass`  in  1  1 = force BPSK regardless of mode.
- `ctrl_mode`  in  3  bit0: 0 = BPSK, 1 = QPSK; bits 2:1 ignored.
- `ctrl_sw_reset`  in  1  one-cycle synchronous datapath flush.
- `in_valid` / `in_ready` / `in_last`  in/out/in  1 each  byte stream handshake; `in_last` marks the final byte of a frame.
- `in_data`  in  8  byte, bit0 is transmitted first.
- `out_valid` / `out_ready` / `out_last`  out/in/out  1 each  symbol stream handshake.
- `out_data`  out  32  {I[15:0], Q[15:0]}, signed Q1.15.
- `sym_count`  out  SYM_COUNT_W  symbols handed off; wraps modulo 2^SYM_COUNT_W.
- `busy`  out  1  high while a byte is held or `out_valid` is high.

## Operation
- **Mode latch:** K is set on byte load: `need2 = ~ctrl_bypass & ctrl_mode[0]`, so K = 2 when `need2` is 1, else 1. K is held with the byte. A mode change mid-byte takes effect on the next byte.
- **State:**
  - `byte_buf[7:0]`
  - `have_byte`
  - `bits_left` (0..8)
  - `k_lat`
  - `last_lat`
- **Emit condition:** `adv = ~out_valid | out_ready`. A symbol is emitted when `have_byte & adv`.
- **Emit action:**
  - b0 = `byte_buf[0]`; b1 = `byte_buf[1]` if `k_lat` = 2.
  - `byte_buf` shifts right by `k_lat`; `bits_left` decrements by `k_lat`.
- **Mapping, QPSK:** I = b0 ? −AMP_QPSK : +AMP_QPSK; Q = b1 ? −AMP_QPSK : +AMP_QPSK. This is the same Gray convention as the slicer: bit0 = sign(I), bit1 = sign(Q), 1 = negative.
- **Mapping, BPSK:** I = b0 ? −AMP_BPSK : +AMP_BPSK; Q = 16'h0000.
- **Negation:** two's complement, 16-bit, no saturation (AMP ≤ 16'h7FFF, so no overflow).
- **`out_last`:** set on the symbol that empties a byte whose `last_lat` = 1. All other symbols have `out_last` = 0.
- **`in_ready`:** `ctrl_enable & (~have_byte | (bits_left == k_lat & adv))`. This allows back-to-back bytes with no bubble.
- **Byte accept (`in_valid & in_ready`):**
  - `byte_buf ← in_data`, `bits_left ← 8`, `have_byte ← 1`.
  - `k_lat` and `last_lat` are latched.
- **`have_byte` clear:** `have_byte` clears when the final symbol of a byte is emitted and no new byte is accepted in the same cycle.
- **`ctrl_enable` low:** new bytes are refused, but the held byte and output register still drain.
- **`ctrl_sw_reset`:**
  - Clears `have_byte`, `bits_left`, `last_lat`, `out_valid` and `out_last`. Any partial byte is discarded.
  - Takes priority over a simultaneous accept or emit.
  - `sym_count` is not cleared.
- **`sym_count`:** increments on `out_valid & out_ready`.

## Timing
- **Reset values (`rst` = 1, asynchronous):**
  - `out_valid`, `out_last`, `out_data`, `in_ready`, `busy`: 0
  - `sym_count`: 0
  - all internal state: 0
- **Latency:** byte handshake at edge N → `have_byte` after N → first symbol `out_valid` after edge N+1.
- **Throughput:** one symbol per cycle while `out_ready` = 1. BPSK takes 8 cycles per byte, QPSK takes 4.
- **Output stability:** `out_data` and `out_last` are held stable while `out_valid & ~out_ready`. Per AXIS rules, `out_valid` is never dropped without a handshake, except on `ctrl_sw_reset` or `rst`.
- **Combinational path:** `in_ready` depends combinationally on `out_ready`. There are no other combinational paths from input to output.
- **Reset mid-byte:** the remaining bits are dropped and the next accepted byte starts at bit0.

## Test plan
- **QPSK, single byte:** send 0xB4 with `in_last` = 1, `out_ready` = 1 → `out_data` = 0x5A825A82, 0xA57E5A82, 0xA57EA57E, 0x5A82A57E, with `out_last` on the 4th symbol only; first `out_valid` 2 cycles after the input handshake.
- **BPSK:** `ctrl_mode` = 0, byte 0x01 → 0x80010000 then seven beats of 0x7FFF0000. With `ctrl_bypass` = 1 and `ctrl_mode` = 1, the output is identical.
- **Back-to-back and backpressure:**
  - 16 QPSK bytes with `in_valid` held high and `out_ready` = 1 → 64 consecutive symbols with no bubble; `sym_count` = 64.
  - Random `out_ready` → same symbol sequence; `out_data` is stable while stalled.
- **Mode change mid-byte:** switch `ctrl_mode` 1→0 after symbol 1 of a QPSK byte → that byte completes as 4 QPSK symbols, and the next byte produces 8 BPSK symbols.
- **`ctrl_sw_reset` mid-byte:** pulse after 2 of 8 BPSK symbols → `out_valid` = 0 next cycle and the partial byte is dropped. The next byte 0xFF gives 8 beats of 0x80010000; `sym_count` keeps its old value plus new symbols.
- **Asynchronous `rst` and `ctrl_enable`:**
  - Asserting `rst` mid-stream clears all outputs immediately.
  - With `ctrl_enable` = 0, `in_ready` = 0 but the held byte drains fully.

Source files
------------

// File: rtl/symbol_mapper.sv
// symbol_mapper: unpacks bytes LSB-first into BPSK/QPSK symbols and maps
// each symbol to a Q1.15 constellation point {I, Q} on a valid/ready stream.
module symbol_mapper #(
  parameter logic [15:0] AMP_BPSK    = 16'h7FFF,
  parameter logic [15:0] AMP_QPSK    = 16'h5A82,
  parameter int          SYM_COUNT_W = 32
) (
  input  logic                   clk_bb,
  input  logic                   rst,
  input  logic                   ctrl_enable,
  input  logic                   ctrl_bypass,
  input  logic [2:0]             ctrl_mode,
  input  logic                   ctrl_sw_reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [31:0]            out_data,
  output logic [SYM_COUNT_W-1:0] sym_count,
  output logic                   busy
);

  localparam logic [15:0] NEG_BPSK = 16'(~AMP_BPSK + 16'd1);
  localparam logic [15:0] NEG_QPSK = 16'(~AMP_QPSK + 16'd1);

  logic [7:0]  byte_buf;
  logic        have_byte;
  logic [3:0]  bits_left;
  logic        k_lat;      // 1 = two bits per symbol (QPSK)
  logic        last_lat;

  logic        adv;
  logic        emit;
  logic        accept;
  logic        last_sym;
  logic        need2;
  logic [3:0]  k_num;
  logic        b0;
  logic        b1;
  logic [15:0] map_i;
  logic [15:0] map_q;

  // Handshake qualifiers and the constellation lookup for the current symbol.
  always_comb begin
    need2    = ~ctrl_bypass & ctrl_mode[0];
    k_num    = k_lat ? 4'd2 : 4'd1;
    adv      = ~out_valid | out_ready;
    emit     = have_byte & adv;
    last_sym = (bits_left == k_num);
    // in_ready is gated by rst so the port reads 0 while reset is held.
    in_ready = ~rst & ctrl_enable & (~have_byte | (last_sym & adv));
    accept   = in_valid & in_ready;
    busy     = have_byte | out_valid;
    b0       = byte_buf[0];
    b1       = k_lat & byte_buf[1];
    if (k_lat) begin
      map_i = b0 ? NEG_QPSK : AMP_QPSK;
      map_q = b1 ? NEG_QPSK : AMP_QPSK;
    end else begin
      map_i = b0 ? NEG_BPSK : AMP_BPSK;
      map_q = 16'h0000;
    end
  end

  // Byte holding register: load on accept, shift out on each emitted symbol.
  always_ff @(posedge clk_bb or posedge rst) begin
    if (rst) begin
      byte_buf  <= 8'h00;
      have_byte <= 1'b0;
      bits_left <= 4'd0;
      k_lat     <= 1'b0;
      last_lat  <= 1'b0;
    end else if (ctrl_sw_reset) begin
      have_byte <= 1'b0;
      bits_left <= 4'd0;
      last_lat  <= 1'b0;
    end else if (accept) begin
      byte_buf  <= in_data;
      bits_left <= 4'd8;
      have_byte <= 1'b1;
      k_lat     <= need2;
      last_lat  <= in_last;
    end else if (emit) begin
      byte_buf  <= k_lat ? {2'b00, byte_buf[7:2]} : {1'b0, byte_buf[7:1]};
      bits_left <= bits_left - k_num;
      if (last_sym) have_byte <= 1'b0;
    end
  end

  // Output register: new symbol whenever the slot is free, hold while stalled.
  always_ff @(posedge clk_bb or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 32'h0;
    end else if (ctrl_sw_reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= {map_i, map_q};
      out_last  <= last_sym & last_lat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Count every symbol handed downstream; survives the datapath flush.
  always_ff @(posedge clk_bb or posedge rst) begin
    if (rst) begin
      sym_count <= '0;
    end else if (out_valid & out_ready) begin
      sym_count <= sym_count + {{(SYM_COUNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_symbol_mapper.sv
// tb_symbol_mapper: directed stimulus with a queue-based scoreboard and an
// independent output monitor that also checks data stability under stall.
module tb_symbol_mapper;

  localparam logic [15:0] PB = 16'h7FFF, NB = 16'h8001;
  localparam logic [15:0] PQ = 16'h5A82, NQ = 16'hA57E;

  logic        clk_bb = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_enable = 1'b1;
  logic        ctrl_bypass = 1'b0;
  logic [2:0]  ctrl_mode = 3'b001;
  logic        ctrl_sw_reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [31:0] out_data;
  logic [31:0] sym_count;
  logic        busy;

  symbol_mapper dut (
    .clk_bb(clk_bb), .rst(rst), .ctrl_enable(ctrl_enable),
    .ctrl_bypass(ctrl_bypass), .ctrl_mode(ctrl_mode),
    .ctrl_sw_reset(ctrl_sw_reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_data(out_data),
    .sym_count(sym_count), .busy(busy)
  );

  always #5 clk_bb = ~clk_bb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [32:0] exp_q[$];
  int n_popped = 0;
  int hs_cnt = 0, hs_first = 0, hs_last = 0;
  bit rand_rdy = 1'b0;
  logic [31:0] held_data;
  bit held_last, held_valid = 1'b0;

  always @(posedge clk_bb) cyc <= cyc + 1;

  always @(negedge clk_bb) out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare each handshaken symbol against the scoreboard.
  always @(negedge clk_bb) begin
    logic [32:0] e;
    #1;
    if (rst || !out_valid) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check("stall_data", out_data, held_data);
        check("stall_last", out_last, held_last);
      end
      if (out_ready) begin
        held_valid = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_symbol", {out_last, out_data}, 33'h0);
        end else begin
          e = exp_q.pop_front();
          check("sym_data", out_data, e[31:0]);
          check("sym_last", out_last, e[32]);
        end
        n_popped++;
        if (hs_cnt == 0) hs_first = cyc;
        hs_last = cyc;
        hs_cnt++;
      end else begin
        held_valid = 1'b1;
        held_data = out_data;
        held_last = out_last;
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input bit k2, input bit last);
    logic [7:0] b = d;
    int nsym = k2 ? 4 : 8;
    for (int s = 0; s < nsym; s++) begin
      logic [15:0] i, q;
      if (k2) begin
        i = b[0] ? NQ : PQ;
        q = b[1] ? NQ : PQ;
        b = b >> 2;
      end else begin
        i = b[0] ? NB : PB;
        q = 16'h0000;
        b = b >> 1;
      end
      exp_q.push_back({(last && s == nsym - 1), i, q});
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input bit hold);
    int n = 0;
    @(negedge clk_bb);
    in_valid = 1'b1; in_data = d; in_last = last;
    #1;
    while (!in_ready && n < 500) begin
      @(negedge clk_bb); #1; n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
    end else begin
      push_exp(d, !ctrl_bypass && ctrl_mode[0], last);
      @(posedge clk_bb); #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk_bb); #2; n++;
    end
    check("drain", {exp_q.size() != 0, busy}, 2'b00);
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (n_popped < target && n < 500) begin
      @(negedge clk_bb); #2; n++;
    end
    check("pop_wait", n_popped >= target, 1'b1);
  endtask

  logic [7:0] b2b [16] = '{8'hB4, 8'h00, 8'hFF, 8'h1B, 8'hE4, 8'h55, 8'hAA, 8'h0F,
                           8'hF0, 8'h39, 8'hC6, 8'h81, 8'h7E, 8'h12, 8'h34, 8'h56};

  initial begin
    logic [31:0] sc0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sym_count", sym_count, 32'h0);
    @(negedge clk_bb); rst = 1'b0;

    // 16 QPSK bytes back to back: 64 symbols on consecutive cycles
    hs_cnt = 0;
    for (int i = 0; i < 16; i++) send_byte(b2b[i], i == 15, i != 15);
    wait_drain();
    check("b2b_count", hs_cnt, 64);
    check("b2b_no_bubble", hs_last - hs_first, 63);
    check("b2b_sym_count", sym_count, 32'd64);

    // Single QPSK byte 0xB4, hand-computed symbols and latency
    send_byte(8'hB4, 1'b1, 1'b0);
    check("lat_not_yet", out_valid, 1'b0);
    @(posedge clk_bb); #1;
    check("lat_first_valid", out_valid, 1'b1);
    check("lat_first_data", out_data, 32'h5A825A82);
    wait_drain();

    // BPSK 0x01, then bypass with QPSK mode selected
    ctrl_mode = 3'b000;
    send_byte(8'h01, 1'b1, 1'b0);
    wait_drain();
    ctrl_mode = 3'b111; ctrl_bypass = 1'b1;
    send_byte(8'h01, 1'b1, 1'b0);
    wait_drain();
    ctrl_bypass = 1'b0; ctrl_mode = 3'b001;

    // Random backpressure on the same byte sequence
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(b2b[i], i == 15, i != 15);
    wait_drain();
    rand_rdy = 1'b0;

    // Mode change after the first symbol of a QPSK byte
    n_popped = 0;
    send_byte(8'hC9, 1'b0, 1'b0);
    wait_pops(1);
    ctrl_mode = 3'b000;
    send_byte(8'h5A, 1'b1, 1'b0);
    wait_drain();

    // Flush after two of eight BPSK symbols
    sc0 = sym_count;
    n_popped = 0;
    send_byte(8'h00, 1'b1, 1'b0);
    wait_pops(2);
    ctrl_sw_reset = 1'b1;
    @(posedge clk_bb); #1;
    ctrl_sw_reset = 1'b0;
    check("swr_out_valid", out_valid, 1'b0);
    check("swr_busy", busy, 1'b0);
    exp_q.delete();
    send_byte(8'hFF, 1'b1, 1'b0);
    wait_drain();
    check("swr_sym_count", sym_count, sc0 + 32'd10);

    // ctrl_enable low refuses new bytes but drains the held one
    send_byte(8'h96, 1'b1, 1'b0);
    ctrl_enable = 1'b0;
    @(negedge clk_bb); in_valid = 1'b1; #1;
    check("en_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_drain();
    ctrl_enable = 1'b1;

    // Asynchronous reset mid-byte, then recovery starting at bit0
    n_popped = 0;
    send_byte(8'hF0, 1'b0, 1'b0);
    wait_pops(3);
    #1; rst = 1'b1; #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_sym_count", sym_count, 32'h0);
    check("arst_in_ready", in_ready, 1'b0);
    exp_q.delete();
    @(negedge clk_bb); rst = 1'b0;
    ctrl_mode = 3'b001;
    send_byte(8'h02, 1'b1, 1'b0);
    wait_drain();
    check("arst_recover_count", sym_count, 32'd4);

    check("queue_empty_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
